// File: rtl/mul_pkg.sv
// Shared constants and the reference product for the pipelined multiplier.
// Operands of the reference function are limited to 64 bits.
package mul_pkg;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_STAGES    = 2;
   localparam int DEF_TAG_WIDTH = 5;
   localparam int DEF_SLICE_W   = DEF_WIDTH / 2;
   localparam int REF_MAX_W     = 64;

   function automatic int mul_slice_w(input int width);
      return width / 2;
   endfunction

   // Low 2*width bits of the (width+1)-bit signed product described by the sign flags.
   function automatic logic [2*REF_MAX_W-1:0] mul_ref_product(
      input logic [REF_MAX_W-1:0] x,
      input logic [REF_MAX_W-1:0] y,
      input logic                 sx,
      input logic                 sy,
      input int                   width
   );
      logic        [REF_MAX_W-1:0]   m;
      logic        [REF_MAX_W-1:0]   xs;
      logic        [REF_MAX_W-1:0]   ys;
      logic signed [2*REF_MAX_W-1:0] ax;
      logic signed [2*REF_MAX_W-1:0] ay;
      logic signed [2*REF_MAX_W-1:0] p;
      logic        [2*REF_MAX_W-1:0] m2;
      m  = (width >= REF_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
      m2 = (width >= REF_MAX_W) ? '1 : ((128'd1 << (2 * width)) - 128'd1);
      xs = x >> (width - 1);
      ys = y >> (width - 1);
      ax = $signed({64'h0, x & m});
      ay = $signed({64'h0, y & m});
      if (sx && xs[0]) ax = ax | $signed({64'hFFFF_FFFF_FFFF_FFFF, ~m});
      if (sy && ys[0]) ay = ay | $signed({64'hFFFF_FFFF_FFFF_FFFF, ~m});
      p = ax * ay;
      return p & m2;
   endfunction

endpackage

// File: rtl/mul_pipe_reg.sv
// One valid/ready pipeline slot: holds {valid, payload}, accepts whenever it is
// empty or its content is leaving, and drops its valid bit on flush.
module mul_pipe_reg #(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 up_valid,
   output logic                 up_ready,
   input  logic [PAYLOAD_W-1:0] up_data,
   output logic                 dn_valid,
   input  logic                 dn_ready,
   output logic [PAYLOAD_W-1:0] dn_data
);

   logic                 valid_q, valid_d;
   logic [PAYLOAD_W-1:0] data_q, data_d;

   always_comb begin
      up_ready = ~valid_q | dn_ready;
      valid_d  = valid_q;
      data_d   = data_q;
      if (up_ready) valid_d = up_valid;
      if (up_ready && up_valid) data_d = up_data;
      if (flush) valid_d = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign dn_valid = valid_q;
   assign dn_data  = data_q;

endmodule

// File: rtl/pipelined_multiplier.sv
// Fully pipelined mixed-signedness multiplier: slot 0 holds four half-width partial
// products, slot 1 their sum, later slots only delay. Valid/ready on both sides.
module pipelined_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int STAGES    = DEF_STAGES,
   parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     input1,
   input  logic [WIDTH-1:0]     input2,
   input  logic                 signed1,
   input  logic                 signed2,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic [TAG_WIDTH-1:0] out_tag
);

   localparam int H     = mul_slice_w(WIDTH);
   localparam int PP_W  = WIDTH + 2;
   localparam int RES_W = 2 * WIDTH;
   localparam int P0_W  = TAG_WIDTH + 4 * PP_W;
   localparam int PN_W  = TAG_WIDTH + RES_W;

   logic            vld [0:STAGES];
   logic            rdy [0:STAGES];
   logic [P0_W-1:0] p0_in, p0_out;
   logic [PN_W-1:0] pn_in  [1:STAGES-1];
   logic [PN_W-1:0] pn_out [1:STAGES-1];

   logic [H-1:0]    a_lo, b_lo;
   logic [H:0]      a_hi, b_hi;
   logic [PP_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

   function automatic logic [PP_W-1:0] ext_lo(input logic [H-1:0] s);
      return {{(PP_W-H){1'b0}}, s};
   endfunction

   function automatic logic [PP_W-1:0] ext_hi(input logic [H:0] s);
      return {{(PP_W-H-1){s[H]}}, s};
   endfunction

   function automatic logic [RES_W-1:0] sext_pp(input logic [PP_W-1:0] p);
      return {{(RES_W-PP_W){p[PP_W-1]}}, p};
   endfunction

   function automatic logic [RES_W-1:0] sum_pp(
      input logic [PP_W-1:0] ll,
      input logic [PP_W-1:0] lh,
      input logic [PP_W-1:0] hl,
      input logic [PP_W-1:0] hh
   );
      return sext_pp(ll) + (sext_pp(lh) << H) + (sext_pp(hl) << H) + (sext_pp(hh) << WIDTH);
   endfunction

   // Low slices are unsigned; high slices carry the operand's extension bit, so every
   // partial product fits WIDTH+2 bits and modular multiplication is exact.
   always_comb begin
      a_lo  = input1[H-1:0];
      b_lo  = input2[H-1:0];
      a_hi  = {signed1 & input1[WIDTH-1], input1[WIDTH-1:H]};
      b_hi  = {signed2 & input2[WIDTH-1], input2[WIDTH-1:H]};
      pp_ll = ext_lo(a_lo) * ext_lo(b_lo);
      pp_lh = ext_lo(a_lo) * ext_hi(b_hi);
      pp_hl = ext_hi(a_hi) * ext_lo(b_lo);
      pp_hh = ext_hi(a_hi) * ext_hi(b_hi);
   end

   assign vld[0]      = in_valid & ~flush;
   assign in_ready    = ~flush & rdy[0];
   assign rdy[STAGES] = out_ready;
   assign p0_in       = {in_tag, pp_hh, pp_hl, pp_lh, pp_ll};
   assign pn_in[1]    = {p0_out[P0_W-1 -: TAG_WIDTH],
                         sum_pp(p0_out[PP_W-1:0], p0_out[2*PP_W-1 -: PP_W],
                                p0_out[3*PP_W-1 -: PP_W], p0_out[4*PP_W-1 -: PP_W])};

   for (genvar k = 0; k < STAGES; k++) begin : g_slot
      if (k == 0) begin : g_pp
         mul_pipe_reg #(.PAYLOAD_W(P0_W)) u_slot (
            .clock    (clock),
            .reset    (reset),
            .flush    (flush),
            .up_valid (vld[0]),
            .up_ready (rdy[0]),
            .up_data  (p0_in),
            .dn_valid (vld[1]),
            .dn_ready (rdy[1]),
            .dn_data  (p0_out)
         );
      end else begin : g_sum
         mul_pipe_reg #(.PAYLOAD_W(PN_W)) u_slot (
            .clock    (clock),
            .reset    (reset),
            .flush    (flush),
            .up_valid (vld[k]),
            .up_ready (rdy[k]),
            .up_data  (pn_in[k]),
            .dn_valid (vld[k+1]),
            .dn_ready (rdy[k+1]),
            .dn_data  (pn_out[k])
         );
         if (k < STAGES - 1) begin : g_link
            assign pn_in[k+1] = pn_out[k];
         end
      end
   end

   assign out_valid         = vld[STAGES];
   assign {out_tag, result} = pn_out[STAGES-1];

   // Recombining the incoming partial products must reproduce the reference product.
   logic [127:0]     ref_full;
   logic [RES_W-1:0] sum_now;

   always_comb begin
      ref_full = mul_ref_product(64'(input1), 64'(input2), signed1, signed2, WIDTH);
      sum_now  = sum_pp(pp_ll, pp_lh, pp_hl, pp_hh);
      if (reset && in_valid) assert (128'(sum_now) == ref_full);
   end

endmodule

// File: doc/pipelined_multiplier.md
# pipelined_multiplier

Parametrised, fully pipelined integer multiplier with per-operand signedness, valid/ready handshakes on both sides, a pass-through tag and a synchronous flush. It is the next-generation replacement for the fixed two-stage 32-bit multiplier in the MIPS CPU execute stage. It serves MULT/MULTU and any future mixed-sign or narrower-width multiply. The flush input lets the pipeline discard in-flight operations on exceptions or branch squash.

## Interface
- WIDTH, 32, operand width in bits; must be even and ≥ 4.
- STAGES, 2, pipeline depth (input register to result register); must be ≥ 2.
- TAG_WIDTH, 5, width of the opaque tag, e.g. destination/HI-LO id.

- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept this cycle.
- input1  in  WIDTH  multiplicand.
- input2  in  WIDTH  multiplier.
- signed1  in  1  treat input1 as two's complement.
- signed2  in  1  treat input2 as two's complement.
- in_tag  in  TAG_WIDTH  carried unchanged to out_tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- result  out  2*WIDTH  product.
- out_tag  out  TAG_WIDTH  tag of the presented result.

## Operation
- Arithmetic: a = {signed1 & input1[WIDTH-1], input1} and b = {signed2 & input2[WIDTH-1], input2}, both WIDTH+1 bits signed. result is the low 2*WIDTH bits of a*b.
- This covers unsigned×unsigned, signed×signed and signed×unsigned exactly.
- Stage 1 registers four partial products of the half-width operand slices. Each slice is sign-extended according to its operand's flag.
- Stage 2 sums the partial products. Stages 3..STAGES are pure delay registers. Each stage holds {valid, tag, data}.
- Transfer in: occurs when in_valid & in_ready. Transfer out: occurs when out_valid & out_ready.
- Stall: stage k advances when stage k+1 is empty or advancing. The last stage advances on out_ready.
- Bubbles collapse: an empty stage always accepts.
- in_ready = !flush & (stage1 empty | stage1 advancing). It is combinational from out_ready. No combinational path runs from in_valid to out_valid.
- Ordering: strictly FIFO. No loss or duplication under any out_ready pattern.
- Flush: clears every stage valid bit at the next edge. No input is accepted in a flush cycle. Data and tag registers need not clear.
- result and out_tag remain stable while out_valid & !out_ready.

## Timing
- Reset (asynchronous, effective immediately): all valid bits, result and out_tag go to 0. After reset, in_ready = 1 and out_valid = 0.
- Latency: an operand accepted at edge N appears with out_valid high after edge N+STAGES−1, i.e. it is consumable STAGES cycles after acceptance.
- Throughput: one operation per cycle while out_ready = 1.
- Full: with all STAGES slots occupied and out_ready = 0, in_ready = 0.
- Full with out_ready = 1: in_ready = 1 in the same cycle (simultaneous pop and push).
- Flush concurrent with out_ready: the presented result is not considered transferred. The consumer must ignore it.
- Reset asserted mid-operation: all in-flight results are lost and outputs drop to 0 without waiting for a clock edge.

## Structure
- Package mul_pkg holds:
  - default WIDTH/STAGES/TAG_WIDTH constants;
  - a function computing the reference extended product, shared by RTL assertions and the bench;
  - the partial-product slice width localparam.
- Sub-module mul_pipe_reg: one valid/ready pipeline slot, parametrised on payload width, instantiated STAGES times via generate. Stage 1 and 2 logic sits between slots in the top module.

## Test plan
- Unsigned, WIDTH=32: 0xFFFFFFFF×0xFFFFFFFF with signed1=signed2=0 → result 0xFFFFFFFE00000001 exactly 2 cycles after acceptance, tag preserved.
- Signed corners, both sign flags set:
  - 0xFFFFFFFF×0xFFFFFFFF → 0x0000000000000001;
  - 0x80000000×0x80000000 → 0x4000000000000000;
  - 0x80000000×0x00000001 → 0xFFFFFFFF80000000.
- Mixed signedness: signed1=1, signed2=0, 0xFFFFFFFF×0x00000002 → 0xFFFFFFFFFFFFFFFE. With signed1=0, signed2=1 and the same operands → 0x00000001FFFFFFFE.
- Backpressure: stream tags 1..6 back-to-back and hold out_ready=0 for 4 cycles.
  - in_ready must drop after 2 acceptances.
  - Results must emerge in tag order 1..6 with none missing or repeated, and result stable while stalled.
- Flush: with 2 ops in flight, pulse flush for 1 cycle.
  - Neither op appears on the output.
  - in_ready is 0 during the flush cycle.
  - An op issued the next cycle returns correctly.
- Reset and random: drop reset between clock edges with ops in flight; out_valid and result must read 0 before the next edge. Then run 10 000 random ops with random signed flags and random out_ready against the mul_pkg reference function, with WIDTH=16, STAGES=3 and with WIDTH=32, STAGES=2.
